// File: rtl/aud_seq_ctrl_if.sv
// Bundle of key, recorder/player status and command signals for aud_seq_ctrl.
// Keys and commands are single-cycle pulses; there is no back-pressure on either side.
interface aud_seq_ctrl_if #(
  parameter int ADDR_W = 20
) ();
  logic              i_key_start;
  logic              i_key_pause;
  logic              i_key_stop;
  logic              i_mode_rec;
  logic [ADDR_W-1:0] i_rec_addr;
  logic              i_rec_full;
  logic [ADDR_W-1:0] i_play_addr;
  logic              o_rec_start;
  logic              o_rec_pause;
  logic              o_rec_stop;
  logic              o_play_start;
  logic              o_play_pause;
  logic              o_play_stop;
  logic [ADDR_W-1:0] o_sram_addr;
  logic              o_sram_we_n;
  logic [ADDR_W-1:0] o_rec_len;
  logic [2:0]        o_state;

  modport master (
    output i_key_start, i_key_pause, i_key_stop, i_mode_rec,
    output i_rec_addr, i_rec_full, i_play_addr,
    input  o_rec_start, o_rec_pause, o_rec_stop,
    input  o_play_start, o_play_pause, o_play_stop,
    input  o_sram_addr, o_sram_we_n, o_rec_len, o_state
  );

  modport slave (
    input  i_key_start, i_key_pause, i_key_stop, i_mode_rec,
    input  i_rec_addr, i_rec_full, i_play_addr,
    output o_rec_start, o_rec_pause, o_rec_stop,
    output o_play_start, o_play_pause, o_play_stop,
    output o_sram_addr, o_sram_we_n, o_rec_len, o_state
  );
endinterface

// File: rtl/aud_seq_ctrl.sv
// Record/play sequencer for a shared audio SRAM: keys in, recorder/player command pulses out.
// Define AUD_SEQ_LOOP_EN to make playback restart at end of recording instead of stopping.
module aud_seq_ctrl #(
  parameter int ADDR_W = 20
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  aud_seq_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_REC        = 3'd1,
    S_REC_PAUSE  = 3'd2,
    S_PLAY       = 3'd3,
    S_PLAY_PAUSE = 3'd4
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] rec_len;
  logic              rec_start_q, rec_pause_q, rec_stop_q;
  logic              play_start_q, play_pause_q, play_stop_q;
  logic              key_stop, key_pause, key_start;
  logic              play_end;
`ifdef AUD_SEQ_LOOP_EN
  logic              loop_restart;
`endif

  // Stop masks pause and start; pause masks start.
  assign key_stop  = bus.i_key_stop;
  assign key_pause = !bus.i_key_stop && bus.i_key_pause;
  assign key_start = !bus.i_key_stop && !bus.i_key_pause && bus.i_key_start;
  assign play_end  = (bus.i_play_addr >= rec_len);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= S_IDLE;
      rec_len      <= '0;
      rec_start_q  <= 1'b0;
      rec_pause_q  <= 1'b0;
      rec_stop_q   <= 1'b0;
      play_start_q <= 1'b0;
      play_pause_q <= 1'b0;
      play_stop_q  <= 1'b0;
`ifdef AUD_SEQ_LOOP_EN
      loop_restart <= 1'b0;
`endif
    end else begin
      rec_start_q  <= 1'b0;
      rec_pause_q  <= 1'b0;
      rec_stop_q   <= 1'b0;
      play_start_q <= 1'b0;
      play_pause_q <= 1'b0;
      play_stop_q  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (key_start && bus.i_mode_rec) begin
            state       <= S_REC;
            rec_len     <= '0;
            rec_start_q <= 1'b1;
          end else if (key_start && (rec_len != '0)) begin
            state        <= S_PLAY;
            play_start_q <= 1'b1;
          end
        end
        S_REC: begin
          if (key_stop || bus.i_rec_full) begin
            state      <= S_IDLE;
            rec_len    <= bus.i_rec_addr;
            rec_stop_q <= 1'b1;
          end else if (key_pause) begin
            state       <= S_REC_PAUSE;
            rec_pause_q <= 1'b1;
          end
        end
        S_REC_PAUSE: begin
          if (key_stop) begin
            state      <= S_IDLE;
            rec_len    <= bus.i_rec_addr;
            rec_stop_q <= 1'b1;
          end else if (key_pause || key_start) begin
            state       <= S_REC;
            rec_start_q <= 1'b1;
          end
        end
        S_PLAY: begin
`ifdef AUD_SEQ_LOOP_EN
          // End of recording issues stop now and a restart on the following cycle.
          if (key_stop) begin
            state        <= S_IDLE;
            play_stop_q  <= 1'b1;
            loop_restart <= 1'b0;
          end else if (loop_restart) begin
            play_start_q <= 1'b1;
            loop_restart <= 1'b0;
          end else if (play_end) begin
            play_stop_q  <= 1'b1;
            loop_restart <= 1'b1;
          end else if (key_pause) begin
            state        <= S_PLAY_PAUSE;
            play_pause_q <= 1'b1;
          end
`else
          if (key_stop || play_end) begin
            state       <= S_IDLE;
            play_stop_q <= 1'b1;
          end else if (key_pause) begin
            state        <= S_PLAY_PAUSE;
            play_pause_q <= 1'b1;
          end
`endif
        end
        S_PLAY_PAUSE: begin
          if (key_stop) begin
            state       <= S_IDLE;
            play_stop_q <= 1'b1;
          end else if (key_pause || key_start) begin
            state        <= S_PLAY;
            play_start_q <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.o_rec_start  = rec_start_q;
  assign bus.o_rec_pause  = rec_pause_q;
  assign bus.o_rec_stop   = rec_stop_q;
  assign bus.o_play_start = play_start_q;
  assign bus.o_play_pause = play_pause_q;
  assign bus.o_play_stop  = play_stop_q;
  assign bus.o_rec_len    = rec_len;
  assign bus.o_state      = state;
  assign bus.o_sram_we_n  = (state != S_REC);
  assign bus.o_sram_addr  = ((state == S_REC) || (state == S_REC_PAUSE)) ?
                            bus.i_rec_addr : bus.i_play_addr;

endmodule

// File: doc/aud_seq_ctrl.md
AUD_SEQ_CTRL -- requirements
Module: aud_seq_ctrl

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 20, the SRAM word-address width.
REQ-002 The block SHALL have port i_clk  input  1  system clock; all state updates on rising edge.
REQ-003 The block SHALL have port i_rst_n  input  1  reset, asynchronous, active-low.
REQ-004 The block SHALL have ports i_key_start, i_key_pause, i_key_stop  input  1 each  debounced single-cycle key pulses.
REQ-005 The block SHALL have port i_mode_rec  input  1  mode select: 1 = record, 0 = play; sampled only on start.
REQ-006 The block SHALL have port i_rec_addr  input  ADDR_W  current recorder write address.
REQ-007 The block SHALL have port i_rec_full  input  1  recorder reached last address.
REQ-008 The block SHALL have port i_play_addr  input  ADDR_W  current player read address.
REQ-009 The block SHALL have ports o_rec_start, o_rec_pause, o_rec_stop  output  1 each  recorder command pulses.
REQ-010 The block SHALL have ports o_play_start, o_play_pause, o_play_stop  output  1 each  player command pulses.
REQ-011 The block SHALL have ports o_sram_addr  output  ADDR_W  and o_sram_we_n  output  1: shared SRAM address and active-low write enable.
REQ-012 The block SHALL have ports o_rec_len  output  ADDR_W  (recorded word count) and o_state  output  3  (current state code).

Function
REQ-013 The FSM SHALL use states IDLE=0, REC=1, REC_PAUSE=2, PLAY=3, PLAY_PAUSE=4; codes 5-7 SHALL return to IDLE on the next cycle.
REQ-014 Same-cycle key priority SHALL be stop > pause > start; lower-priority keys in that cycle are ignored.
REQ-015 In IDLE, start with i_mode_rec=1 SHALL go to REC and clear o_rec_len to 0; start with i_mode_rec=0 SHALL go to PLAY only if o_rec_len != 0, otherwise stay in IDLE with no command pulse.
REQ-016 In REC, pause SHALL go to REC_PAUSE; REC_PAUSE + start or pause SHALL resume REC. PLAY/PLAY_PAUSE SHALL behave identically with the play commands.
REQ-017 Stop in any non-IDLE state SHALL go to IDLE.
REQ-018 In REC, i_rec_full=1 SHALL act as stop (auto-stop), taking priority below a key stop.
REQ-019 In PLAY, i_play_addr >= o_rec_len SHALL act as stop (end of recording).
REQ-020 Every transition SHALL emit exactly one 1-cycle pulse on the matching o_*_start/pause/stop, registered, asserted the cycle after the triggering input; no two command outputs SHALL be high together.
REQ-021 Leaving REC or REC_PAUSE for IDLE SHALL latch o_rec_len <= i_rec_addr in the same edge that registers the stop pulse.
REQ-022 o_sram_addr SHALL equal i_rec_addr in REC/REC_PAUSE, else i_play_addr; combinational from the state register.
REQ-023 o_sram_we_n SHALL be 0 only in REC; 1 in all other states, including REC_PAUSE.
REQ-024 Start in REC or PLAY, and pause in IDLE, SHALL be ignored.

Reset
REQ-025 Asserting i_rst_n low SHALL immediately force IDLE, o_rec_len=0, all command pulses 0, o_sram_we_n=1, o_state=0, including mid-recording; no stop pulse SHALL be issued.
REQ-026 The first start accepted after reset release SHALL be honoured on the first clock edge at which it is sampled.

Configuration
REQ-027 With macro AUD_SEQ_LOOP_EN defined, the end-of-recording condition in PLAY (REQ-019) SHALL issue o_play_stop then, one cycle later, o_play_start and remain in PLAY (loop); only a key stop SHALL exit.
REQ-028 Without AUD_SEQ_LOOP_EN, REQ-019 SHALL apply unchanged and no loop logic SHALL be present.

Verification
REQ-029 Reset, start with mode_rec=1 -> o_rec_start pulse 1 cycle later, o_state=1, we_n=0, sram_addr tracks i_rec_addr.
REQ-030 REC with i_rec_addr=0x00123, key stop -> o_rec_stop pulse, o_state=0, o_rec_len=0x00123, we_n=1.
REQ-031 After reset, play start -> no pulse, state stays 0; after recording rec_len=0x10, play start -> PLAY; i_play_addr=0x10 -> o_play_stop, IDLE (looped variant: stop then start, stays 3).
REQ-032 Start, pause and stop in the same cycle during REC -> only o_rec_stop, state IDLE.
REQ-033 REC with i_rec_full=1 -> auto o_rec_stop, o_rec_len = i_rec_addr (0xFFFFF).
REQ-034 i_rst_n low in REC_PAUSE -> immediate IDLE, o_rec_len=0, no pulses.
